wb_trace_fifo: RTL

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

---
 rtl/wb_trace_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/wb_trace_fifo.sv
// Trace FIFO capturing register-file and data-memory write events from a CPU core.
// Up to two events enter per cycle (GRF first); the head is presented first-word-fall-through.
module wb_trace_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     grf_we,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wdata,
    input  logic                     dm_we,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_type,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_q, drop_d;

    logic            grf_ev_s, dm_ev_s, pop_s, push_grf_s, push_dm_s;
    logic [CW-1:0]   cap_s;
    logic [1:0]      n_drop_s;
    logic [16:0]     drop_sum_s;
    logic [AW-1:0]   dm_slot_s;
    entry_t          head_s;

    // Admission: capacity counts a same-edge pop; GRF wins the last free slot.
    always_comb begin
        grf_ev_s   = grf_we && (grf_addr != 5'd0);
        dm_ev_s    = dm_we;
        pop_s      = (count_q != {CW{1'b0}}) && out_ready;
        cap_s      = CW'(DEPTH) - count_q + CW'(pop_s);
        push_grf_s = grf_ev_s && (cap_s != {CW{1'b0}});
        push_dm_s  = dm_ev_s && (cap_s > CW'(push_grf_s));
        n_drop_s   = {1'b0, grf_ev_s && !push_grf_s} + {1'b0, dm_ev_s && !push_dm_s};
        dm_slot_s  = wr_ptr_q + AW'(push_grf_s);
        drop_sum_s = {1'b0, drop_q} + {15'd0, n_drop_s};
        wr_ptr_d   = wr_ptr_q + AW'(push_grf_s) + AW'(push_dm_s);
        rd_ptr_d   = rd_ptr_q + AW'(pop_s);
        count_d    = count_q + CW'(push_grf_s) + CW'(push_dm_s) - CW'(pop_s);
        overflow_d = overflow_q || (n_drop_s != 2'd0);
        if (drop_sum_s[16]) begin
            drop_d = 16'hFFFF;
        end else begin
            drop_d = drop_sum_s[15:0];
        end
    end

    // Control state: pointers, occupancy and sticky drop accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage; contents are don't-care until covered by count, so no reset.
    always_ff @(posedge clk) begin
        if (reset && push_grf_s) begin
            mem_q[wr_ptr_q] <= '{typ: 1'b0, pc: pc, addr: {27'd0, grf_addr}, data: grf_wdata};
        end
        if (reset && push_dm_s) begin
            mem_q[dm_slot_s] <= '{typ: 1'b1, pc: pc, addr: dm_addr, data: dm_wdata};
        end
    end

    // Head presentation, zeroed whenever the FIFO is empty.
    always_comb begin
        head_s    = mem_q[rd_ptr_q];
        out_valid = (count_q != {CW{1'b0}});
        out_type  = 1'b0;
        out_pc    = 32'd0;
        out_addr  = 32'd0;
        out_data  = 32'd0;
        if (out_valid) begin
            out_type = head_s.typ;
            out_pc   = head_s.pc;
            out_addr = head_s.addr;
            out_data = head_s.data;
        end else begin
            out_type = 1'b0;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule
